spi_master_arbiter: RTL and testbench
=====================================

Name: spi_master_arbiter

Overview:
- Shares one SPI master (AXI4-Lite slave register port) between two requesters: requester 0 is the boot/flash loader, requester 1 is the CPU data path.
- Each requester uses a simple valid/ready request and one-cycle response interface.
- The arbiter grants round-robin and performs exactly one AXI4-Lite write or read transaction downstream per grant.
- It waits for the SPI master's response, returns it to the owner, and enforces a timeout.

Parameters:
- ADDR_W, 32, address width (matches ADRES_BIT).
- DATA_W, 32, data width (matches VERI_BIT).
- TIMEOUT_CYC, 1024, maximum cycles from issue to response before abort (at most 65535).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 request.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  encoded SPI address (bit24 = write op, bit25 = read op).
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  one-cycle accept pulse.
- rsp0_valid  out  1  one-cycle response pulse.
- rsp0_rdata  out  DATA_W  read data.
- rsp0_err  out  1  timeout flag, qualified by rsp0_valid.
- req1_*, rsp1_*  same as requester 0, for requester 1.
- m_awaddr  out  ADDR_W
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  DATA_W
- m_wvalid  out  1
- m_wready  in  1
- m_bvalid  in  1
- m_bready  out  1
- m_araddr  out  ADDR_W
- m_arvalid  out  1
- m_arready  in  1
- m_rvalid  in  1
- m_rdata  in  DATA_W
- m_rready  out  1

Behaviour:
- Reset (ARESETN=0 at a posedge): all outputs 0, state IDLE, last-grant pointer = 1 (so requester 0 wins the first tie), timeout counter 0. Reset mid-transaction abandons it silently: no rsp pulse, downstream valids drop the next edge.
- States are one-hot: IDLE=4'b0001, ISSUE=4'b0010, WAIT=4'b0100, RESP=4'b1000.
- IDLE:
  - Single requester asserting valid: it is granted.
  - Both asserting: grant the one that is not the last-grant pointer.
  - In the grant cycle: reqN_ready=1 (combinational), latch write/addr/wdata/owner, update pointer, go to ISSUE next edge.
  - No request: stay in IDLE.
- ISSUE:
  - Write: m_awvalid=m_wvalid=1 with latched addr/data. Handshake when m_awvalid & m_awready & m_wready in the same cycle.
  - Read: m_arvalid=1 with latched addr. Handshake when m_arready.
  - Valids stay high and payload stays stable until the handshake. On handshake, valids drop the next cycle and the state goes to WAIT.
- WAIT:
  - m_bready=1 for writes, m_rready=1 for reads.
  - Write: first cycle with m_bvalid=1 captures rdata=0, err=0, then RESP.
  - Read: first cycle with m_rvalid=1 captures m_rdata, err=0, then RESP.
  - The response is looked for only in WAIT, so a valid still lingering from the previous transaction (high for several cycles downstream) is never consumed twice. The SPI master keeps ready low while its valid is high.
- RESP: rspN_valid=1 for exactly one cycle for the latched owner only, with rdata/err. Next state IDLE.
- Latency: request seen in IDLE → downstream valid at +1 cycle → rsp pulse 1 cycle after the downstream response cycle. Minimum re-arbitration gap is 1 cycle (the RESP→IDLE edge).
- Timeout:
  - The 16-bit counter clears on grant and increments each cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYC-1: deassert all m_* valids/readies, go to RESP with err=1 and rdata=0.
  - The counter saturates and never wraps.
- Simultaneous events:
  - A response arriving in the same cycle the timeout expires counts as success (err=0).
  - A request from the current owner while a transaction is in flight is not accepted until IDLE.
  - A requester may drop reqN_valid after its ready pulse.
- The arbiter does no address checking; malformed ops (bit24/25 clear) rely on the timeout.

Decomposition:
- Package spi_arb_pkg: state encodings, TIMEOUT default, op-bit positions (WR_OP_BIT=24, RD_OP_BIT=25).
- One natural sub-module, rr_arbiter2: two requests in, last-grant pointer, one-hot grant out, pointer update on accept.
- FSM, latch registers and timeout stay in spi_master_arbiter.

Test Plan:
- Write, single requester:
  - Stimulus: req0 write, addr=32'h0100_0008, wdata=32'hA5; slave model ready=1, bvalid 20 cycles after accept.
  - Required: req0_ready at cycle 0; m_awvalid/m_wvalid at cycle 1 carrying exactly the request values; rsp0_valid one cycle after bvalid; err=0; rdata=0.
- Read, single requester:
  - Stimulus: req1 read, addr=32'h0200_3208; model returns m_rdata=32'h0000_00C3, with rvalid held 5 cycles.
  - Required: exactly one rsp1_valid with rdata=32'hC3; no rsp0 activity.
- Round-robin:
  - Stimulus: req0 and req1 both held continuously from reset, 4 transactions.
  - Required: grant order 0,1,0,1; each owner receives only its own responses.
- Backpressure:
  - Stimulus: m_awready=1 but m_wready=0 for 7 cycles, then both 1.
  - Required: valids and payload stable all 7 cycles; exactly one handshake.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, slave never responds.
  - Required: rsp0_valid with err=1, rdata=0, 16 cycles after grant; m_* valids low afterwards; next request is served normally.
- Reset in WAIT:
  - Stimulus: ARESETN=0 for 1 cycle.
  - Required: all outputs 0 the next cycle; no rsp pulse; req0 wins the first tie after reset.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared encodings and constants for the two-requester SPI master arbiter.
package spi_arb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_WAIT  = 4'b0100,
        ST_RESP  = 4'b1000
    } state_t;

    localparam int TIMEOUT_DEFAULT = 1024;
    localparam int CNT_W           = 16;

    // Op bits inside the encoded SPI address; decoded by the SPI master, not here.
    localparam int WR_OP_BIT = 24;
    localparam int RD_OP_BIT = 25;

endpackage

// File: rtl/spi_master_arbiter_rr.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer starts at 1 so requester 0 wins the first tie out of reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one AXI4-Lite SPI master between two requesters, one transaction per grant,
// with a response timeout. dbg_state exposes the one-hot FSM state.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_rready,
    output logic [3:0]        dbg_state
);

    // Expiry fires in the cycle whose increment brings the counter to TIMEOUT_CYC-1,
    // so the error response lands TIMEOUT_CYC cycles after the grant.
    localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYC - 2);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                lat_write_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_wdata_q;
    logic                owner_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [1:0]          grant;
    logic                accept;
    logic                expire;
    logic                cap_en;
    logic [DATA_W-1:0]   cap_rdata;
    logic                cap_err;

    rr_arbiter2 u_rr (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .req     ({req1_valid, req0_valid}),
        .accept  (accept),
        .grant   (grant)
    );

    assign accept     = ARESETN && (state_q == ST_IDLE) && (grant != 2'b00);
    assign req0_ready = accept && grant[0];
    assign req1_ready = accept && grant[1];
    assign expire     = (cnt_q >= EXPIRE_AT);

    assign m_awaddr  = lat_addr_q;
    assign m_araddr  = lat_addr_q;
    assign m_wdata   = lat_wdata_q;
    assign dbg_state = state_q;

    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) && owner_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

    always_comb begin
        state_d   = state_q;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_arvalid = 1'b0;
        m_bready  = 1'b0;
        m_rready  = 1'b0;
        cap_en    = 1'b0;
        cap_rdata = '0;
        cap_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                m_awvalid = lat_write_q;
                m_wvalid  = lat_write_q;
                m_arvalid = !lat_write_q;
                if (expire) begin
                    state_d = ST_RESP;
                    cap_en  = 1'b1;
                    cap_err = 1'b1;
                end else if (lat_write_q ? (m_awready && m_wready) : m_arready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                m_bready = lat_write_q;
                m_rready = !lat_write_q;
                // A response in the expiry cycle still counts as success.
                if (lat_write_q ? m_bvalid : m_rvalid) begin
                    state_d   = ST_RESP;
                    cap_en    = 1'b1;
                    cap_rdata = lat_write_q ? '0 : m_rdata;
                end else if (expire) begin
                    state_d = ST_RESP;
                    cap_en  = 1'b1;
                    cap_err = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            owner_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q     <= grant[1];
                lat_write_q <= grant[1] ? req1_write : req0_write;
                lat_addr_q  <= grant[1] ? req1_addr  : req0_addr;
                lat_wdata_q <= grant[1] ? req1_wdata : req0_wdata;
                cnt_q       <= '0;
            end else if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cap_en) begin
                rdata_q <= cap_rdata;
                err_q   <= cap_err;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: main instance with the default timeout,
// second instance with a 16-cycle timeout for the abort path.
module tb_spi_master_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN;

    logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  dbg_state;

    logic        t_req0_valid, t_req0_write, t_req0_ready, t_rsp0_valid, t_rsp0_err;
    logic [31:0] t_req0_addr, t_req0_wdata, t_rsp0_rdata;
    logic        t_req1_valid, t_req1_write, t_req1_ready, t_rsp1_valid, t_rsp1_err;
    logic [31:0] t_req1_addr, t_req1_wdata, t_rsp1_rdata;
    logic [31:0] t_m_awaddr, t_m_wdata, t_m_araddr, t_m_rdata;
    logic        t_m_awvalid, t_m_awready, t_m_wvalid, t_m_wready, t_m_bvalid, t_m_bready;
    logic        t_m_arvalid, t_m_arready, t_m_rvalid, t_m_rready;
    logic [3:0]  t_dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    spi_master_arbiter u_dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
        .dbg_state(dbg_state)
    );

    spi_master_arbiter #(.TIMEOUT_CYC(16)) u_dut_to (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req0_valid(t_req0_valid), .req0_write(t_req0_write), .req0_addr(t_req0_addr),
        .req0_wdata(t_req0_wdata), .req0_ready(t_req0_ready), .rsp0_valid(t_rsp0_valid),
        .rsp0_rdata(t_rsp0_rdata), .rsp0_err(t_rsp0_err),
        .req1_valid(t_req1_valid), .req1_write(t_req1_write), .req1_addr(t_req1_addr),
        .req1_wdata(t_req1_wdata), .req1_ready(t_req1_ready), .rsp1_valid(t_rsp1_valid),
        .rsp1_rdata(t_rsp1_rdata), .rsp1_err(t_rsp1_err),
        .m_awaddr(t_m_awaddr), .m_awvalid(t_m_awvalid), .m_awready(t_m_awready),
        .m_wdata(t_m_wdata), .m_wvalid(t_m_wvalid), .m_wready(t_m_wready),
        .m_bvalid(t_m_bvalid), .m_bready(t_m_bready),
        .m_araddr(t_m_araddr), .m_arvalid(t_m_arvalid), .m_arready(t_m_arready),
        .m_rvalid(t_m_rvalid), .m_rdata(t_m_rdata), .m_rready(t_m_rready),
        .dbg_state(t_dbg_state)
    );

    // clock / reset
    always #5 ACLK = ~ACLK;

    // Inputs change 2 time units after the rising edge; checks run 1 unit later.
    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] main_outs();
        return {req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err,
                m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
    endfunction

    logic [31:0] rd;
    logic        er, ok, got, exp_owner;
    int          n0, n1, hs, w;

    initial begin
        ARESETN = 1'b0;
        {req0_valid, req0_write, req1_valid, req1_write} = '0;
        {req0_addr, req0_wdata, req1_addr, req1_wdata} = '0;
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        m_rdata = '0;
        {t_req0_valid, t_req0_write, t_req1_valid, t_req1_write} = '0;
        {t_req0_addr, t_req0_wdata, t_req1_addr, t_req1_wdata} = '0;
        {t_m_awready, t_m_wready, t_m_bvalid, t_m_arready, t_m_rvalid} = '0;
        t_m_rdata = '0;

        // ---- power-on reset ----
        cyc(); cyc();
        ARESETN = 1'b1;
        #1;
        chk("reset_ctrl", main_outs(), 64'h0);
        chk("reset_data", {m_awaddr, m_wdata} | {m_araddr, rsp0_rdata | rsp1_rdata}, 64'h0);
        chk("reset_state", dbg_state, 4'b0001);

        // ---- write, single requester ----
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        cyc();
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h0100_0008; req0_wdata = 32'hA5;
        #1;
        chk("wr_ready0", {req1_ready, req0_ready}, 2'b01);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("wr_valids", {m_awvalid, m_wvalid, m_arvalid}, 3'b110);
        chk("wr_payload", {m_awaddr, m_wdata}, {32'h0100_0008, 32'hA5});
        cyc();
        #1;
        chk("wr_wait", {m_awvalid, m_wvalid, m_bready, dbg_state}, {3'b001, 4'b0100});
        ok = 1'b1;
        for (int i = 3; i < 20; i++) begin
            cyc(); #1;
            if (rsp0_valid || rsp1_valid || dbg_state != 4'b0100) ok = 1'b0;
        end
        chk("wr_no_early_rsp", ok, 1'b1);
        cyc();
        m_bvalid = 1'b1;
        cyc();
        m_bvalid = 1'b0;
        #1;
        chk("wr_rsp", {rsp1_valid, rsp0_valid, rsp0_err}, 3'b010);
        chk("wr_rdata", rsp0_rdata, 32'h0);
        cyc(); #1;
        chk("wr_rsp_once", {rsp0_valid, dbg_state}, {1'b0, 4'b0001});

        // ---- read, single requester, lingering rvalid ----
        cyc();
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h0200_3208;
        #1;
        chk("rd_ready1", {req1_ready, req0_ready}, 2'b10);
        cyc();
        req1_valid = 1'b0;
        #1;
        chk("rd_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b100);
        chk("rd_addr", m_araddr, 32'h0200_3208);
        cyc(); #1;
        chk("rd_wait", {m_arvalid, m_rready}, 2'b01);
        m_rvalid = 1'b1; m_rdata = 32'h0000_00C3;
        n0 = 0; n1 = 0; rd = '0; er = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 5) begin m_rvalid = 1'b0; m_rdata = '0; end
            #1;
            if (rsp1_valid) begin n1++; rd = rsp1_rdata; er = rsp1_err; end
            if (rsp0_valid) n0++;
        end
        chk("rd_rsp_count", n1, 1);
        chk("rd_rdata", {rd, 31'h0, er}, {32'hC3, 32'h0});
        chk("rd_no_rsp0", n0, 0);

        // ---- backpressure on the write data channel ----
        m_wready = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h0100_0010; req0_wdata = 32'h5A;
        #1;
        chk("bp_ready0", req0_ready, 1'b1);
        cyc();
        req0_valid = 1'b0;
        ok = 1'b1; hs = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (!(m_awvalid && m_wvalid && m_awaddr == 32'h0100_0010 && m_wdata == 32'h5A)) ok = 1'b0;
            if (m_awvalid && m_awready && m_wready) hs++;
            cyc();
        end
        m_wready = 1'b1;
        #1;
        if (!(m_awvalid && m_wvalid && m_awaddr == 32'h0100_0010 && m_wdata == 32'h5A)) ok = 1'b0;
        if (m_awvalid && m_awready && m_wready) hs++;
        chk("bp_stable", ok, 1'b1);
        cyc(); #1;
        if (m_awvalid && m_awready && m_wready) hs++;
        chk("bp_handshakes", hs, 1);
        chk("bp_wait", {m_awvalid, m_wvalid, m_bready}, 3'b001);
        m_bvalid = 1'b1;
        cyc();
        m_bvalid = 1'b0;
        #1;
        chk("bp_rsp", {rsp0_valid, rsp0_err}, 2'b10);
        cyc();

        // ---- reset while waiting for a response ----
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h0100_0020; req1_wdata = 32'h77;
        cyc();
        req1_valid = 1'b0;
        cyc(); #1;
        chk("rst_in_wait", dbg_state, 4'b0100);
        ARESETN = 1'b0; m_bvalid = 1'b1;
        cyc();
        ARESETN = 1'b1; m_bvalid = 1'b0;
        #1;
        chk("rst_outs", main_outs(), 64'h0);
        chk("rst_state", dbg_state, 4'b0001);
        n0 = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            if (rsp0_valid || rsp1_valid || m_awvalid || m_wvalid) n0++;
        end
        chk("rst_no_rsp", n0, 0);

        // ---- round-robin with both requesters held ----
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i % 2));
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h0100_0030; req0_wdata = 32'h11;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h0100_0040; req1_wdata = 32'h22;
        for (int t = 0; t < 4; t++) begin
            #1;
            w = 0;
            while (!(req0_ready || req1_ready) && w < 4) begin cyc(); #1; w++; end
            chk("rr_grant_seen", req0_ready || req1_ready, 1'b1);
            exp_owner = exp_q.pop_front() != 0;
            got = req1_ready;
            chk("rr_order", got, exp_owner);
            cyc(); #1;
            chk("rr_wdata", m_wdata, exp_owner ? 32'h22 : 32'h11);
            cyc();
            m_bvalid = 1'b1;
            cyc();
            m_bvalid = 1'b0;
            #1;
            chk("rr_rsp_owner", {rsp1_valid, rsp0_valid}, exp_owner ? 2'b10 : 2'b01);
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_queue_drained", exp_q.size(), 0);
        cyc(); cyc();

        // ---- timeout on the 16-cycle instance ----
        t_m_awready = 1'b1; t_m_wready = 1'b1;
        t_req0_valid = 1'b1; t_req0_write = 1'b1; t_req0_addr = 32'h0100_0050; t_req0_wdata = 32'h33;
        #1;
        chk("to_ready0", t_req0_ready, 1'b1);
        w = 0;
        do begin
            cyc();
            t_req0_valid = 1'b0;
            #1;
            w++;
        end while (!t_rsp0_valid && w < 40);
        chk("to_latency", w, 16);
        chk("to_rsp", {t_rsp0_valid, t_rsp0_err, t_rsp1_valid}, 3'b110);
        chk("to_rdata", t_rsp0_rdata, 32'h0);
        chk("to_m_idle", {t_m_awvalid, t_m_wvalid, t_m_bready, t_m_arvalid, t_m_rready}, 5'b0);
        cyc(); #1;
        chk("to_after", {t_rsp0_valid, t_m_awvalid, t_m_wvalid, t_m_bready, t_dbg_state}, {4'b0, 4'b0001});
        t_req0_valid = 1'b1; t_req0_addr = 32'h0100_0060; t_req0_wdata = 32'h44;
        #1;
        chk("to_next_ready", t_req0_ready, 1'b1);
        cyc();
        t_req0_valid = 1'b0;
        #1;
        chk("to_next_issue", {t_m_awvalid, t_m_awaddr}, {1'b1, 32'h0100_0060});
        cyc();
        t_m_bvalid = 1'b1;
        cyc();
        t_m_bvalid = 1'b0;
        #1;
        chk("to_next_rsp", {t_rsp0_valid, t_rsp0_err}, 2'b10);
        cyc();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
